rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter and destination scoreboard for the 32×32 register file's single write port. Up to NREQ write-back sources (ALU, LSU, MDU) present destination/data with a valid/ready handshake. The block grants one source per cycle by round-robin and drives the register file `we`/`waddr`/`wdata` from a registered output stage. It also keeps a per-register busy bitmap that the issue stage uses to stall on pending destinations.

## Interface

Parameters:
- `NREQ`, 3: number of write-back requesters (2..4).
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk` in 1: clock. All state changes on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: requester i has a write pending.
- `req_addr` in NREQ*AW: destination of requester i, packed at `[i*AW +: AW]`.
- `req_data` in NREQ*DW: data of requester i, packed at `[i*DW +: DW]`.
- `req_ready` out NREQ: one-hot grant; the handshake completes when `req_valid[i] & req_ready[i]`.
- `rsv_valid` in 1: issue stage reserves a destination this cycle.
- `rsv_addr` in AW: destination being reserved.
- `busy` out 32: bit r=1 means a write to r is outstanding.
- `rf_we` out 1: register file write enable.
- `rf_waddr` out AW: register file write address.
- `rf_wdata` out DW: register file write data.

## Operation

- **Arbitration**
  - Round-robin over `req_valid`. The search starts at `(last_grant+1) mod NREQ`.
  - `last_grant` updates only on a completed handshake.
  - `req_ready` is combinational and at most one-hot. It is 0 when no request is valid.
- **Output stage**
  - On a handshake, the registered stage loads `rf_waddr`/`rf_wdata` with the granted request.
  - `rf_we` = 1 only if the granted address ≠ 0.
  - A write to r0 is still accepted (ready=1) but produces `rf_we=0`.
  - With no handshake, `rf_we` = 0 next cycle. `rf_waddr`/`rf_wdata` hold their last values.
- **Scoreboard**
  - `rsv_valid` with `rsv_addr≠0` sets `busy[rsv_addr]`.
  - An output-stage write with `rf_we=1` clears `busy[rf_waddr]` on the same edge the register file captures the data.
  - If a set and a clear hit the same address on the same edge, the set wins (a newer producer is pending).
  - `busy[0]` is constant 0.
  - Reserving an already-busy register is legal; the bit stays 1 (no count).

## Timing

- **Reset**
  - Values after reset: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, `last_grant`=NREQ-1 (so requester 0 has first priority). `req_ready` then follows the inputs combinationally.
  - Reset asserted mid-operation discards the output-stage write and clears all busy bits at that edge; in-flight requests are not acknowledged.
- **Latency**
  - Handshake at edge E0 → `rf_we`=1 during cycle E0..E1 → register file written at E1, busy bit cleared at E1.
  - Sustained throughput is one write per cycle.
- **Handshake**
  - Requesters hold `req_valid`/`req_addr`/`req_data` stable until ready.
  - `req_ready` never depends on the requester's own data.
  - A requester with `req_valid` continuously asserted is granted within NREQ cycles.
- Two requesters writing the same address are serialized in grant order; the last grant's data ends up in the register file.

## Configuration

- **`RF_WB_BYPASS_EN` defined**
  - Adds inputs `byp_addr_a` and `byp_addr_b` (AW) and outputs `byp_hit_a`/`byp_hit_b` (1) and `byp_data_a`/`byp_data_b` (DW).
  - `byp_hit_x` = `rf_we & (rf_waddr==byp_addr_x) & (byp_addr_x≠0)`, combinational.
  - `byp_data_x` = `rf_wdata`.
  - Decode uses these to read data during the cycle before the register file array captures it.
- **Undefined**: the ports are absent, and readers must stall on `busy` until the write lands.

## Structure

- Package `rf_pkg`:
  - `AW`, `DW`, `NREQ_MAX`, `ZERO_REG` (5'd0).
  - Typedef `wb_req_t` {valid, addr, data}.
- Sub-module `rr_arbiter`:
  - Parameter N; inputs `req[N]` and `advance`.
  - Output `gnt[N]` one-hot.
  - Holds the pointer internally and advances it when `advance` is high.
- The top level holds the output register, the busy bitmap and the optional bypass comparators.

## Test plan

- Reset, then `req_valid=3'b001`, addr 5, data 0xDEADBEEF → `req_ready=001`; next cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`; following cycle `rf_we=0`.
- All three requesters held valid for 6 cycles → grants 0,1,2,0,1,2; six consecutive `rf_we` pulses with the matching data.
- Requester 1 writes addr 0 → `req_ready[1]=1`, `rf_we` stays 0, `busy` unchanged.
- Reserve r7 → `busy[7]=1`. Write r7 via a requester → `busy[7]` clears at the edge `rf_we` is sampled. Repeat with `rsv_valid`/`rsv_addr=7` on that clearing edge → `busy[7]` remains 1.
- Assert `rst` while `rf_we=1` and `busy=0x80` → the next cycle shows `rf_we=0`, `busy=0`, and the next grant goes to requester 0.
- With `RF_WB_BYPASS_EN`: grant a write to r9 with 0x1234 and set `byp_addr_a=9` → `byp_hit_a=1`, `byp_data_a=0x1234` during the `rf_we` cycle. With `byp_addr_a=0` → `byp_hit_a=0`.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and the write-back request record for the register-file write port.
// Bus widths are combinational definitions only; nothing here is registered.
package rf_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NREQ_MAX = 4;

  localparam logic [AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin grant over N requesters: the combinational one-hot grant searches from the slot after the last winner.
// The pointer moves only when the caller reports a completed handshake, so a stalled grant keeps its priority.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) ptr_d = PW'(i);
      end
    end
  end

  // Reset to the last slot so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PW'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter + busy scoreboard for the register file's single write port; grant is combinational, write lands one edge after the handshake.
// Unselected requesters simply see ready=0 and hold; RF_WB_BYPASS_EN adds forwarding comparators on the pending write.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = rf_pkg::AW,
  parameter int DW   = rf_pkg::DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_addr,
  output logic [31:0]        busy,
`ifdef RF_WB_BYPASS_EN
  input  logic [AW-1:0]      byp_addr_a,
  input  logic [AW-1:0]      byp_addr_b,
  output logic               byp_hit_a,
  output logic               byp_hit_b,
  output logic [DW-1:0]      byp_data_a,
  output logic [DW-1:0]      byp_data_b,
`endif
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata
);

  import rf_pkg::*;

  logic [NREQ-1:0] gnt;
  wb_req_t         gnt_req;

  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [31:0]     busy_q, busy_d;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (gnt_req.valid),
    .gnt     (gnt)
  );

  // No acknowledgement while reset is held, so in-flight requesters keep their data.
  assign req_ready = rst ? '0 : gnt;

  always_comb begin
    gnt_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        gnt_req.valid = req_valid[i];
        gnt_req.addr  = req_addr[i*AW +: AW];
        gnt_req.data  = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt_req.valid) begin
      we_d    = (gnt_req.addr != ZERO_REG);
      waddr_d = gnt_req.addr;
      wdata_d = gnt_req.data;
    end
  end

  // Set after clear: a reservation landing with the retiring write belongs to a newer producer.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (rsv_valid && (rsv_addr != ZERO_REG)) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy     = busy_q;

`ifdef RF_WB_BYPASS_EN
  assign byp_hit_a  = we_q && (waddr_q == byp_addr_a) && (byp_addr_a != ZERO_REG);
  assign byp_hit_b  = we_q && (waddr_q == byp_addr_b) && (byp_addr_b != ZERO_REG);
  assign byp_data_a = wdata_q;
  assign byp_data_b = wdata_q;
`endif

endmodule
